// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - control-bundle layout and ALUOp encodings shared by the pipeline stages
package riscv_pipe_pkg;

  localparam int CTRL_W = 9;

  localparam int CTRL_BRANCH   = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_ALUOP_LO = 6;
  localparam int CTRL_ALUOP_HI = 7;
  localparam int CTRL_LUI      = 8;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } alu_op_e;

endpackage

// File: rtl/ld_use_hazard.sv
// rtl/ld_use_hazard.sv - combinational load-use hazard detector (load in EX feeding the ID instruction)
module ld_use_hazard #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_valid,
  input  logic              id_lui,
  input  logic              id_alu_src,
  input  logic              id_mem_write,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  output logic              hz
);

  logic use1;
  logic use2;
  logic load_in_ex;

  // A store reads rs2 as its data even though ALUSrc selects the immediate.
  assign use1 = ~id_lui;
  assign use2 = ~id_alu_src | id_mem_write;

  assign load_in_ex = ex_valid & ex_mem_read & (ex_rd != '0);

  assign hz = load_in_ex & id_valid &
              ((use1 & (ex_rd == id_rs1)) | (use2 & (ex_rd == id_rs2)));

endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with load-use stall and flush bubble
// Optional bubble counter output enabled by ID_EX_BUBBLE_CNT_EN.
module id_ex_pipe_reg
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7_b5,
  input  logic              ex_flush,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7_b5,
`ifdef ID_EX_BUBBLE_CNT_EN
  output logic [31:0]       bubble_cnt,
`endif
  output logic              stall_o
);

  logic hz;
  logic bubble;
  logic load_valid;

  ld_use_hazard #(.REG_AW(REG_AW)) u_hazard (
    .ex_valid     (ex_valid),
    .ex_mem_read  (ex_ctrl[CTRL_MEMREAD]),
    .ex_rd        (ex_rd),
    .id_valid     (id_valid),
    .id_lui       (id_ctrl[CTRL_LUI]),
    .id_alu_src   (id_ctrl[CTRL_ALUSRC]),
    .id_mem_write (id_ctrl[CTRL_MEMWRITE]),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .hz           (hz)
  );

  // The ID instruction is wrong-path under a flush, so holding it would be pointless.
  assign stall_o    = hz & ~ex_flush;
  assign bubble     = ex_flush | hz;
  assign load_valid = id_valid & ~bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_ctrl      <= CTRL_NOP;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_funct3    <= '0;
      ex_funct7_b5 <= 1'b0;
    end else begin
      ex_valid     <= load_valid;
      ex_ctrl      <= load_valid ? id_ctrl : CTRL_NOP;
      // Data fields follow ID even into a bubble; only valid/ctrl carry meaning there.
      ex_pc        <= id_pc;
      ex_rs1_data  <= id_rs1_data;
      ex_rs2_data  <= id_rs2_data;
      ex_imm       <= id_imm;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_funct3    <= id_funct3;
      ex_funct7_b5 <= id_funct7_b5;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (bubble && (bubble_cnt != 32'hFFFF_FFFF)) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - randomized self-checking bench for id_ex_pipe_reg against a transaction model
module tb_id_ex_pipe_reg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [8:0] C_LW  = 9'h036;
  localparam logic [8:0] C_ADD = 9'h0A0;
  localparam logic [8:0] C_SW  = 9'h018;
  localparam logic [8:0] C_LUI = 9'h130;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              id_valid = 1'b0;
  logic [8:0]        id_ctrl = '0;
  logic [XLEN-1:0]   id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
  logic [REG_AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [2:0]        id_funct3 = '0;
  logic              id_funct7_b5 = 1'b0;
  logic              ex_flush = 1'b0;
  logic              ex_valid;
  logic [8:0]        ex_ctrl;
  logic [XLEN-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0]        ex_funct3;
  logic              ex_funct7_b5;
  logic              stall_o;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0]       bubble_cnt;
`endif

  id_ex_pipe_reg #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7_b5(id_funct7_b5), .ex_flush(ex_flush), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7_b5(ex_funct7_b5),
`ifdef ID_EX_BUBBLE_CNT_EN
    .bubble_cnt(bubble_cnt),
`endif
    .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model of what the EX stage should hold: one instruction record.
  typedef struct {
    logic              valid;
    logic [8:0]        ctrl;
    logic [XLEN-1:0]   pc, a, b, imm;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [2:0]        f3;
    logic              f7;
  } instr_t;

  instr_t m_ex;
  longint m_bubbles;

  function automatic instr_t empty_instr();
    instr_t r;
    r = '{valid: 1'b0, ctrl: '0, pc: '0, a: '0, b: '0, imm: '0, rs1: '0, rs2: '0, rd: '0, f3: '0, f7: 1'b0};
    return r;
  endfunction

  // Load in EX with a nonzero destination that the ID instruction actually reads.
  function automatic logic model_hazard();
    logic reads_rs1, reads_rs2, ex_is_load;
    ex_is_load = m_ex.valid && m_ex.ctrl[1] && (m_ex.rd != 0);
    reads_rs1  = !id_ctrl[8];
    reads_rs2  = !id_ctrl[4] || id_ctrl[3];
    return ex_is_load && id_valid &&
           ((reads_rs1 && m_ex.rd == id_rs1) || (reads_rs2 && m_ex.rd == id_rs2));
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 64'(ex_valid), 64'(m_ex.valid));
    check({tag, ".ctrl"},  64'(ex_ctrl),  64'(m_ex.ctrl));
    if (m_ex.valid) begin
      check({tag, ".pc"},   64'(ex_pc),        64'(m_ex.pc));
      check({tag, ".a"},    64'(ex_rs1_data),  64'(m_ex.a));
      check({tag, ".b"},    64'(ex_rs2_data),  64'(m_ex.b));
      check({tag, ".imm"},  64'(ex_imm),       64'(m_ex.imm));
      check({tag, ".regs"}, 64'({ex_rs1, ex_rs2, ex_rd}), 64'({m_ex.rs1, m_ex.rs2, m_ex.rd}));
      check({tag, ".fn"},   64'({ex_funct3, ex_funct7_b5}), 64'({m_ex.f3, m_ex.f7}));
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    check({tag, ".bcnt"}, 64'(bubble_cnt), 64'(m_bubbles));
`endif
  endtask

  task automatic drive(input logic v, input logic [8:0] c, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic fl);
    id_valid = v; id_ctrl = c; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; ex_flush = fl;
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_funct3 = 3'($urandom); id_funct7_b5 = 1'($urandom);
  endtask

  // Inputs are already driven; check stall, clock once, update model, check EX.
  task automatic step(input string tag, output logic exp_stall);
    logic hz;
    #1;
    hz = model_hazard();
    exp_stall = hz && !ex_flush;
    check({tag, ".stall"}, 64'(stall_o), 64'(exp_stall));
    @(posedge clk);
    if (ex_flush || hz) begin
      m_ex = empty_instr();
      m_bubbles++;
    end else begin
      m_ex = '{valid: id_valid, ctrl: id_valid ? id_ctrl : 9'h0, pc: id_pc, a: id_rs1_data,
               b: id_rs2_data, imm: id_imm, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
               f3: id_funct3, f7: id_funct7_b5};
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".valid"}, 64'(ex_valid), 64'h0);
    check({tag, ".ctrl"},  64'(ex_ctrl),  64'h0);
    check({tag, ".data"},  64'(ex_pc | ex_rs1_data | ex_rs2_data | ex_imm), 64'h0);
    check({tag, ".regs"},  64'({ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7_b5}), 64'h0);
    check({tag, ".stall"}, 64'(stall_o), 64'h0);
`ifdef ID_EX_BUBBLE_CNT_EN
    check({tag, ".bcnt"},  64'(bubble_cnt), 64'h0);
`endif
  endtask

  initial begin
    logic s;
    m_ex = empty_instr();
    m_bubbles = 0;
    repeat (2) @(posedge clk);
    #2;
    check_reset_state("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back ADD then SUB
    drive(1, C_ADD, 5'd3, 5'd1, 5'd2, 0); step("add", s);
    drive(1, C_ADD, 5'd4, 5'd3, 5'd2, 0); id_funct7_b5 = 1'b1; step("sub", s);

    // Load-use: lw x5 then add x6,x5,x1 stalls once, then enters
    drive(1, C_LW, 5'd5, 5'd2, 5'd0, 0); step("lw5", s);
    drive(1, C_ADD, 5'd6, 5'd5, 5'd1, 0); step("lu_stall", s);
    check("lu_stall_seen", 64'(s), 64'h1);
    step("lu_retry", s);
    check("lu_retry_nostall", 64'(s), 64'h0);

    // Store data dependence on rs2
    drive(1, C_LW, 5'd7, 5'd2, 5'd0, 0); step("lw7", s);
    drive(1, C_SW, 5'd0, 5'd2, 5'd7, 0); step("sw_stall", s);
    check("sw_stall_seen", 64'(s), 64'h1);
    step("sw_retry", s);

    // No false stalls: x0 destination, and lui reads nothing
    drive(1, C_LW, 5'd0, 5'd2, 5'd0, 0); step("lw0", s);
    drive(1, C_ADD, 5'd6, 5'd0, 5'd0, 0); step("x0_use", s);
    check("x0_nostall", 64'(s), 64'h0);
    drive(1, C_LW, 5'd5, 5'd2, 5'd0, 0); step("lw5b", s);
    drive(1, C_LUI, 5'd5, 5'd5, 5'd5, 0); step("lui", s);
    check("lui_nostall", 64'(s), 64'h0);

    // Flush overlapping a hazard
    drive(1, C_LW, 5'd5, 5'd2, 5'd0, 0); step("lw5c", s);
    drive(1, C_ADD, 5'd6, 5'd5, 5'd1, 1); step("flush_hz", s);
    check("flush_hz_nostall", 64'(s), 64'h0);

    // Asynchronous reset in the middle of a stall cycle
    drive(1, C_LW, 5'd9, 5'd2, 5'd0, 0); step("lw9", s);
    drive(1, C_ADD, 5'd6, 5'd9, 5'd9, 0);
    #2;
    check("pre_rst_stall", 64'(stall_o), 64'h1);
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_rst");
    m_ex = empty_instr();
    m_bubbles = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic with small register indices to provoke hazards
    for (int i = 0; i < 400; i++) begin
      logic [8:0] c;
      c = ($urandom_range(0, 2) == 0) ? C_LW : 9'($urandom);
      drive($urandom_range(0, 9) < 8, c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
      step("rnd", s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
